cfa_stream_accum: RTL and testbench



---
 rtl/cfa_stream_accum_if.sv | 41 ++++
 rtl/cfa_stream_accum.sv | 178 +++++++++++++++++
 tb/tb_cfa_stream_accum.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cfa_stream_accum_if.sv
// Stream bundle for cfa_stream_accum: operand beat channel in, redundant result channel out.
// CFA_CPA_EN adds the resolved out_sum field.
interface cfa_stream_accum_if #(
    parameter int W = 10,
    parameter int N = 8,
    parameter int G = 8
);
    localparam int OW = W + $clog2(N) + G;

    // Both channels: a transfer happens on the rising clk edge where valid && ready.
    // The source holds payload stable while valid && !ready; valid never waits on ready.
    logic [N*W-1:0] in_data;
    logic           in_valid;
    logic           in_last;
    logic           in_ready;
    logic [OW-1:0]  out_s;
    logic [OW-1:0]  out_c;
    logic [15:0]    out_beats;
    logic           out_ovf;
    logic           out_valid;
    logic           out_ready;
`ifdef CFA_CPA_EN
    logic [OW-1:0]  out_sum;
`endif

    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_s, out_c, out_beats, out_ovf, out_valid
`ifdef CFA_CPA_EN
        , out_sum
`endif
    );

    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_s, out_c, out_beats, out_ovf, out_valid
`ifdef CFA_CPA_EN
        , out_sum
`endif
    );
endinterface

// File: rtl/cfa_stream_accum.sv
// Streaming carry-save accumulator: N operands/beat -> 3:2 tree -> 4:2 frame accumulator -> redundant result.
// Optional macro CFA_CPA_EN adds a carry-propagate out_sum on the result register.
module cfa_stream_accum #(
    parameter int W      = 10,
    parameter int N      = 8,
    parameter int G      = 8,
    parameter int SIGNED = 0
) (
    input logic               clk,
    input logic               rst,
    cfa_stream_accum_if.slave bus
);
    localparam int OW = W + $clog2(N) + G;
    localparam logic [32:0] OVF_LIM = 33'd1 << G;

    if (W < 2 || W > 32) begin : g_bad_w
        $error("cfa_stream_accum: W must be 2..32");
    end
    if (N < 3 || N > 16) begin : g_bad_n
        $error("cfa_stream_accum: N must be 3..16");
    end
    if (G < 0 || G > 31) begin : g_bad_g
        $error("cfa_stream_accum: G must be 0..31");
    end
    if (SIGNED != 0 && SIGNED != 1) begin : g_bad_signed
        $error("cfa_stream_accum: SIGNED must be 0 or 1");
    end

    typedef logic [OW-1:0] vec_t;

    function automatic vec_t ext(input logic [W-1:0] v);
        if (SIGNED != 0) return {{(OW-W){v[W-1]}}, v};
        return {{(OW-W){1'b0}}, v};
    endfunction

    function automatic vec_t csa_s(input vec_t a, input vec_t b, input vec_t c);
        return a ^ b ^ c;
    endfunction

    // Carry out of bit OW-1 falls off the shift: everything is modulo 2^OW.
    function automatic vec_t csa_c(input vec_t a, input vec_t b, input vec_t c);
        return ((a & b) | (a & c) | (b & c)) << 1;
    endfunction

    logic        s1_valid_q, s1_valid_d;
    logic        s1_last_q, s1_last_d;
    vec_t        s1_s_q, s1_s_d, s1_c_q, s1_c_d;
    vec_t        acc_s_q, acc_s_d, acc_c_q, acc_c_d;
    logic        first_q, first_d;
    logic [15:0] cnt_q, cnt_d;
    vec_t        out_s_q, out_s_d, out_c_q, out_c_d;
    logic [15:0] out_beats_q, out_beats_d;
    logic        out_ovf_q, out_ovf_d;
    logic        out_valid_q, out_valid_d;

    vec_t        tree_s, tree_c, tree_op, tree_t;
    vec_t        acc_s_eff, acc_c_eff, m_s, m_c, f_s, f_c;
    logic [15:0] cnt_inc;
    logic        ovf_now;
    logic        s2_go, accept;

    // A finished frame may only enter the result register once the previous one is gone.
    assign s2_go  = s1_valid_q && !(s1_last_q && out_valid_q && !bus.out_ready);
    assign accept = bus.in_valid && bus.in_ready;

    assign bus.in_ready  = !s1_valid_q || s2_go;
    assign bus.out_s     = out_s_q;
    assign bus.out_c     = out_c_q;
    assign bus.out_beats = out_beats_q;
    assign bus.out_ovf   = out_ovf_q;
    assign bus.out_valid = out_valid_q;
`ifdef CFA_CPA_EN
    assign bus.out_sum   = out_s_q + out_c_q;
`endif

    always_comb begin
        tree_s  = ext(bus.in_data[0 +: W]);
        tree_c  = ext(bus.in_data[W +: W]);
        tree_op = '0;
        tree_t  = '0;
        for (int k = 2; k < N; k++) begin
            tree_op = ext(bus.in_data[k*W +: W]);
            tree_t  = csa_s(tree_s, tree_c, tree_op);
            tree_c  = csa_c(tree_s, tree_c, tree_op);
            tree_s  = tree_t;
        end
    end

    always_comb begin
        acc_s_eff = first_q ? '0 : acc_s_q;
        acc_c_eff = first_q ? '0 : acc_c_q;
        m_s       = csa_s(acc_s_eff, acc_c_eff, s1_s_q);
        m_c       = csa_c(acc_s_eff, acc_c_eff, s1_s_q);
        f_s       = csa_s(m_s, m_c, s1_c_q);
        f_c       = csa_c(m_s, m_c, s1_c_q);
        cnt_inc   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
        ovf_now   = {17'd0, cnt_inc} > OVF_LIM;
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_last_d   = s1_last_q;
        s1_s_d      = s1_s_q;
        s1_c_d      = s1_c_q;
        acc_s_d     = acc_s_q;
        acc_c_d     = acc_c_q;
        first_d     = first_q;
        cnt_d       = cnt_q;
        out_s_d     = out_s_q;
        out_c_d     = out_c_q;
        out_beats_d = out_beats_q;
        out_ovf_d   = out_ovf_q;
        out_valid_d = out_valid_q;

        if (accept) begin
            s1_valid_d = 1'b1;
            s1_last_d  = bus.in_last;
            s1_s_d     = tree_s;
            s1_c_d     = tree_c;
        end else if (s2_go) begin
            s1_valid_d = 1'b0;
        end

        if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;

        // A load in the same cycle as a handshake overrides the clear above.
        if (s2_go) begin
            if (s1_last_q) begin
                out_s_d     = f_s;
                out_c_d     = f_c;
                out_beats_d = cnt_inc;
                out_ovf_d   = ovf_now;
                out_valid_d = 1'b1;
                acc_s_d     = '0;
                acc_c_d     = '0;
                cnt_d       = '0;
                first_d     = 1'b1;
            end else begin
                acc_s_d = f_s;
                acc_c_d = f_c;
                cnt_d   = cnt_inc;
                first_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_s_q      <= '0;
            s1_c_q      <= '0;
            acc_s_q     <= '0;
            acc_c_q     <= '0;
            first_q     <= 1'b1;
            cnt_q       <= '0;
            out_s_q     <= '0;
            out_c_q     <= '0;
            out_beats_q <= '0;
            out_ovf_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_last_q   <= s1_last_d;
            s1_s_q      <= s1_s_d;
            s1_c_q      <= s1_c_d;
            acc_s_q     <= acc_s_d;
            acc_c_q     <= acc_c_d;
            first_q     <= first_d;
            cnt_q       <= cnt_d;
            out_s_q     <= out_s_d;
            out_c_q     <= out_c_d;
            out_beats_q <= out_beats_d;
            out_ovf_q   <= out_ovf_d;
            out_valid_q <= out_valid_d;
        end
    end
endmodule

// File: tb/tb_cfa_stream_accum.sv
// Directed bench for cfa_stream_accum: default unsigned build, a signed W=10 build and a W=4,N=3,G=1 build.
module tb_cfa_stream_accum;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    cfa_stream_accum_if #(.W(10), .N(8), .G(8)) bus_a ();
    cfa_stream_accum_if #(.W(10), .N(8), .G(8)) bus_b ();
    cfa_stream_accum_if #(.W(4),  .N(3), .G(1)) bus_c ();

    cfa_stream_accum #(.W(10), .N(8), .G(8), .SIGNED(0)) dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
    cfa_stream_accum #(.W(10), .N(8), .G(8), .SIGNED(1)) dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));
    cfa_stream_accum #(.W(4),  .N(3), .G(1), .SIGNED(0)) dut_c (.clk(clk), .rst(rst), .bus(bus_c.slave));

    int n_cmp = 0;
    int n_err = 0;
    int n_res_a = 0;

    // Expected result entries for dut_a: {ovf, beats[15:0], total[20:0]}
    logic [37:0] exp_q[$];
    logic [37:0] e_a;

    logic [20:0] tot_a, tot_b;
    logic [6:0]  tot_c;
    assign tot_a = bus_a.out_s + bus_a.out_c;
    assign tot_b = bus_b.out_s + bus_b.out_c;
    assign tot_c = bus_c.out_s + bus_c.out_c;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    function automatic logic [37:0] pack(input int tot, input int beats, input logic ovf);
        return {ovf, 16'(beats), 21'(tot)};
    endfunction

    function automatic logic [79:0] ops_1to8();
        logic [79:0] d;
        for (int k = 0; k < 8; k++) d[k*10 +: 10] = 10'(k + 1);
        return d;
    endfunction

    // Scoreboard for dut_a: every output handshake must match the oldest expectation.
    always @(negedge clk) begin
        if (rst === 1'b0 && bus_a.out_valid === 1'b1 && bus_a.out_ready === 1'b1) begin
            n_res_a++;
            chk("a_result_expected", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e_a = exp_q.pop_front();
                chk("a_total", 32'(tot_a), 32'(e_a[20:0]));
                chk("a_beats", 32'(bus_a.out_beats), 32'(e_a[36:21]));
                chk("a_ovf", 32'(bus_a.out_ovf), 32'(e_a[37]));
            end
        end
    end

    task automatic send_a(input logic [79:0] d, input logic last, input logic must_rdy);
        int waited = 0;
        bus_a.in_data  = d;
        bus_a.in_last  = last;
        bus_a.in_valid = 1'b1;
        if (must_rdy) chk("a_rdy_stream", 32'(bus_a.in_ready), 1);
        while (bus_a.in_ready !== 1'b1 && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        if (waited >= 50) chk("a_accept_timeout", 32'(waited), 0);
        @(posedge clk); #1;
        bus_a.in_valid = 1'b0;
        bus_a.in_last  = 1'b0;
    endtask

    task automatic send_frame_a(input logic [79:0] d, input int nbeats, input logic must_rdy);
        for (int i = 0; i < nbeats; i++) send_a(d, (i == nbeats - 1), must_rdy);
    endtask

    task automatic drain_a(input string tag);
        int n = 0;
        while (exp_q.size() > 0 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk(tag, 32'(exp_q.size()), 0);
    endtask

    task automatic run_b(input string tag, input logic [79:0] d, input logic [20:0] exp_tot);
        int n = 0;
        bus_b.in_data  = d;
        bus_b.in_last  = 1'b1;
        bus_b.in_valid = 1'b1;
        @(posedge clk); #1;
        bus_b.in_valid = 1'b0;
        bus_b.in_last  = 1'b0;
        while (bus_b.out_valid !== 1'b1 && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_valid"}, 32'(bus_b.out_valid), 1);
        chk({tag, "_total"}, 32'(tot_b), 32'(exp_tot));
        chk({tag, "_beats"}, 32'(bus_b.out_beats), 1);
`ifdef CFA_CPA_EN
        chk({tag, "_cpa"}, 32'(bus_b.out_sum), 32'(exp_tot));
`endif
        @(posedge clk); #1;
    endtask

    task automatic run_c(input string tag, input logic [11:0] d, input int nbeats,
                         input logic [6:0] exp_tot, input logic exp_ovf);
        int n = 0;
        for (int i = 0; i < nbeats; i++) begin
            bus_c.in_data  = d;
            bus_c.in_last  = (i == nbeats - 1);
            bus_c.in_valid = 1'b1;
            @(posedge clk); #1;
        end
        bus_c.in_valid = 1'b0;
        bus_c.in_last  = 1'b0;
        while (bus_c.out_valid !== 1'b1 && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_valid"}, 32'(bus_c.out_valid), 1);
        chk({tag, "_total"}, 32'(tot_c), 32'(exp_tot));
        chk({tag, "_beats"}, 32'(bus_c.out_beats), 32'(nbeats));
        chk({tag, "_ovf"}, 32'(bus_c.out_ovf), 32'(exp_ovf));
`ifdef CFA_CPA_EN
        chk({tag, "_cpa"}, 32'(bus_c.out_sum), 32'(exp_tot));
`endif
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int snap;
        bus_a.in_data = '0; bus_a.in_valid = 1'b0; bus_a.in_last = 1'b0; bus_a.out_ready = 1'b1;
        bus_b.in_data = '0; bus_b.in_valid = 1'b0; bus_b.in_last = 1'b0; bus_b.out_ready = 1'b1;
        bus_c.in_data = '0; bus_c.in_valid = 1'b0; bus_c.in_last = 1'b0; bus_c.out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_a_out_valid", 32'(bus_a.out_valid), 0);
        chk("rst_a_out_s", 32'(bus_a.out_s), 0);
        chk("rst_a_out_c", 32'(bus_a.out_c), 0);
        chk("rst_a_beats", 32'(bus_a.out_beats), 0);
        chk("rst_a_ovf", 32'(bus_a.out_ovf), 0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_a_in_ready", 32'(bus_a.in_ready), 1);
        chk("rst_c_in_ready", 32'(bus_c.in_ready), 1);

        // Single beat of 1023s: offered after edge t, result visible after edge t+2
        exp_q.push_back(pack(8184, 1, 1'b0));
        bus_a.in_data  = {8{10'h3FF}};
        bus_a.in_last  = 1'b1;
        bus_a.in_valid = 1'b1;
        chk("a_rdy_idle", 32'(bus_a.in_ready), 1);
        @(posedge clk); #1;
        bus_a.in_valid = 1'b0;
        bus_a.in_last  = 1'b0;
        chk("a_lat_edge1", 32'(bus_a.out_valid), 0);
        @(posedge clk); #1;
        chk("a_lat_edge2", 32'(bus_a.out_valid), 1);
`ifdef CFA_CPA_EN
        chk("a_cpa_sum", 32'(bus_a.out_sum), 8184);
`endif
        drain_a("a_drain_single");

        // Four-beat frame of 1..8, full throughput
        exp_q.push_back(pack(144, 4, 1'b0));
        send_frame_a(ops_1to8(), 4, 1'b1);
        drain_a("a_drain_four");

        // Backpressure: two frames stream while the result is not consumed
        bus_a.out_ready = 1'b0;
        exp_q.push_back(pack(144, 4, 1'b0));
        exp_q.push_back(pack(144, 4, 1'b0));
        send_frame_a(ops_1to8(), 4, 1'b0);
        send_frame_a(ops_1to8(), 4, 1'b0);
        chk("a_bp_rdy_low", 32'(bus_a.in_ready), 0);
        for (int i = 0; i < 3; i++) begin
            chk("a_bp_hold_valid", 32'(bus_a.out_valid), 1);
            chk("a_bp_hold_total", 32'(tot_a), 144);
            chk("a_bp_hold_beats", 32'(bus_a.out_beats), 4);
            @(posedge clk); #1;
        end
        chk("a_bp_rdy_still_low", 32'(bus_a.in_ready), 0);
        bus_a.out_ready = 1'b1;
        #1;
        chk("a_bp_rdy_release", 32'(bus_a.in_ready), 1);
        exp_q.push_back(pack(36, 1, 1'b0));
        send_frame_a(ops_1to8(), 1, 1'b0);
        drain_a("a_drain_bp");

        // Held result and partial frame discarded by reset
        bus_a.out_ready = 1'b0;
        send_frame_a(ops_1to8(), 1, 1'b0);
        send_a(ops_1to8(), 1'b0, 1'b0);
        send_a(ops_1to8(), 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("a_midrst_valid", 32'(bus_a.out_valid), 0);
        chk("a_midrst_beats", 32'(bus_a.out_beats), 0);
        rst = 1'b0;
        bus_a.out_ready = 1'b1;
        @(posedge clk); #1;
        snap = n_res_a;
        exp_q.push_back(pack(8, 1, 1'b0));
        send_frame_a({8{10'd1}}, 1, 1'b0);
        drain_a("a_drain_rst");
        repeat (4) @(posedge clk);
        #1;
        chk("a_rst_one_result", 32'(n_res_a - snap), 1);

        // Guard boundary: 256 beats stays within 2^G, 257 flags overflow; frames back-to-back
        exp_q.push_back(pack(9216, 256, 1'b0));
        exp_q.push_back(pack(9252, 257, 1'b1));
        send_frame_a(ops_1to8(), 256, 1'b1);
        send_frame_a(ops_1to8(), 257, 1'b1);
        drain_a("a_drain_ovf");

        // Signed operands, W=10
        run_b("b_minus1", {8{10'h3FF}}, 21'h1FFFF8);
        run_b("b_minus512", {8{10'h200}}, 21'h1FF000);
        run_b("b_mixed", {4{10'h200, 10'h1FF}}, 21'h1FFFFC);

        // W=4, N=3, G=1 (OW=7): overflow once beats exceed 2
        run_c("c_fff_x3", 12'hFFF, 3, 7'd7, 1'b1);
        run_c("c_321_x2", 12'h321, 2, 7'd12, 1'b0);
        run_c("c_907_x1", 12'h907, 1, 7'd16, 1'b0);
        run_c("c_e1f_x3", 12'hE1F, 3, 7'd90, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
